// File: rtl/ipf_if.sv
// ipf_if: stream-side bundle for the inner-product filter slice.
// The master drives commands, input bytes and weights; the slave (ipf) returns results.
interface ipf_if #(
  parameter int In_Width = 8
);
  logic [2:0]          ctrl;
  logic                i_valid;
  logic [In_Width-1:0] i_data;
  logic                w_valid;
  logic [3:0]          w_data;
  logic                res_valid;
  logic [31:0]         res;
  logic                finish;

  modport master (
    output ctrl, i_valid, i_data, w_valid, w_data,
    input  res_valid, res, finish
  );

  modport slave (
    input  ctrl, i_valid, i_data, w_valid, w_data,
    output res_valid, res, finish
  );
endinterface

// File: rtl/ipf.sv
// ipf: inner-product filter slice.
// Keeps a 3-entry circular byte buffer and a 4-bit weight. Each accepted weight load
// snapshots the buffer and emits three results buf[k]*w on consecutive cycles.
// Optional feature macro IPF_SAT_EN: saturate products into Out_Width bits instead of wrapping.
module ipf #(
  parameter int In_Width   = 8,
  parameter int Out_Width  = 9,
  parameter int Addr_Width = 16
) (
  input  logic   clk,
  input  logic   rst,
  ipf_if.slave   bus
);
  localparam int PW = In_Width + 4;

  logic [In_Width-1:0]   buf_q [3];
  logic [In_Width-1:0]   buf_d [3];
  logic [In_Width-1:0]   snap_q [3];
  logic [In_Width-1:0]   snap_d [3];
  logic [1:0]            wptr_q, wptr_d;
  logic [1:0]            k_q, k_d;
  logic [3:0]            w_q, w_d;
  logic                  act_q, act_d;
  logic                  done_q, done_d;
  logic                  endp_q, endp_d;
  logic                  fin_q, fin_d;
  logic                  vld_q, vld_d;
  logic [Out_Width-1:0]  res_q, res_d;
  logic [Addr_Width-1:0] cnt_q, cnt_d;

  logic                  cmd_end, cmd_load;
  logic [In_Width-1:0]   sel_byte;
  logic [PW-1:0]         prod;

  // Map the full product into the result field: clamp or wrap.
  function automatic logic [Out_Width-1:0] scale_f(input logic [PW-1:0] p);
`ifdef IPF_SAT_EN
    if (|(p >> Out_Width)) return '1;
    return p[Out_Width-1:0];
`else
    return p[Out_Width-1:0];
`endif
  endfunction

  // Command decode; unknown or reserved codes fall through to HOLD.
  always_comb begin
    cmd_end  = 1'b0;
    cmd_load = 1'b0;
    case (bus.ctrl)
      3'd0:    cmd_end  = 1'b1;
      3'd1:    cmd_load = bus.w_valid & ~fin_q;
      default: ;
    endcase
  end

  // Select the snapshot entry for the result being issued and form the product.
  always_comb begin
    sel_byte = snap_q[0];
    if (k_q == 2'd1) sel_byte = snap_q[1];
    if (k_q == 2'd2) sel_byte = snap_q[2];
    prod = PW'(sel_byte) * PW'(w_q);
  end

  // Next-state: buffer writes, burst sequencing, end-of-job tracking.
  always_comb begin
    buf_d  = buf_q;
    snap_d = snap_q;
    wptr_d = wptr_q;
    k_d    = k_q;
    w_d    = w_q;
    act_d  = act_q;
    done_d = done_q;
    endp_d = endp_q;
    vld_d  = 1'b0;
    res_d  = res_q;
    cnt_d  = cnt_q;

    if (bus.i_valid) begin
      for (int i = 0; i < 3; i++) begin
        if (wptr_q == 2'(i)) buf_d[i] = bus.i_data;
      end
      wptr_d = (wptr_q == 2'd2) ? 2'd0 : wptr_q + 2'd1;
    end

    // The result already in flight is always delivered, even on a restart edge.
    if (act_q) begin
      vld_d = 1'b1;
      res_d = scale_f(prod);
      cnt_d = cnt_q + 1'b1;
      if (k_q == 2'd2) begin
        act_d  = 1'b0;
        done_d = 1'b1;
      end else begin
        k_d = k_q + 2'd1;
      end
    end

    // END is remembered and released once no burst is running.
    if (cmd_end && (act_q || done_q)) endp_d = 1'b1;
    fin_d = fin_q | (endp_q & ~act_q);

    // A load snapshots the buffer as it stood before this edge and (re)starts the burst.
    if (cmd_load) begin
      w_d    = bus.w_data;
      snap_d = buf_q;
      act_d  = 1'b1;
      k_d    = 2'd0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q  <= '{default: '0};
      snap_q <= '{default: '0};
      wptr_q <= '0;
      k_q    <= '0;
      w_q    <= '0;
      act_q  <= 1'b0;
      done_q <= 1'b0;
      endp_q <= 1'b0;
      fin_q  <= 1'b0;
      vld_q  <= 1'b0;
      res_q  <= '0;
      cnt_q  <= '0;
    end else begin
      buf_q  <= buf_d;
      snap_q <= snap_d;
      wptr_q <= wptr_d;
      k_q    <= k_d;
      w_q    <= w_d;
      act_q  <= act_d;
      done_q <= done_d;
      endp_q <= endp_d;
      fin_q  <= fin_d;
      vld_q  <= vld_d;
      res_q  <= res_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.res_valid = vld_q;
  assign bus.res       = {{(32-Out_Width){1'b0}}, res_q};
  assign bus.finish    = fin_q;
endmodule

// File: tb/tb_ipf.sv
// tb_ipf: directed and randomized checks of ipf against a transaction-level model.
module tb_ipf;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_step  = 0;
  int   n_vld   = 0;

  ipf_if #(.In_Width(8)) bus();

  ipf dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  int mbuf [3];
  int mwp;
  int pend [$];
  bit m_done, m_endreq, m_fin;
  int exp_res;
  bit exp_val;

  function automatic int f(input int p);
`ifdef IPF_SAT_EN
    return (p > 511) ? 511 : p;
`else
    return p % 512;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s step %0d: observed %0d expected %0d", tag, n_step, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) mbuf[i] = 0;
    mwp = 0;
    pend.delete();
    m_done = 0; m_endreq = 0; m_fin = 0;
    exp_res = 0; exp_val = 0;
  endtask

  task automatic step(input logic [2:0] c, input logic iv, input logic [7:0] id,
                      input logic wv, input logic [3:0] wd, input logic r);
    bit busy, fin_next;
    bus.ctrl = c; bus.i_valid = iv; bus.i_data = id;
    bus.w_valid = wv; bus.w_data = wd; rst = r;
    @(posedge clk);
    n_step++;
    if (r) begin
      model_reset();
    end else begin
      busy     = (pend.size() > 0);
      fin_next = m_fin | (m_endreq & !busy);
      if (c == 3'd0 && (busy || m_done)) m_endreq = 1;
      exp_val = 0;
      if (busy) begin
        exp_res = pend.pop_front();
        exp_val = 1;
        if (pend.size() == 0) m_done = 1;
      end
      if (c == 3'd1 && wv && !m_fin) begin
        pend.delete();
        for (int i = 0; i < 3; i++) pend.push_back(f(mbuf[i] * int'(wd)));
      end
      if (iv) begin
        mbuf[mwp] = int'(id);
        mwp = (mwp + 1) % 3;
      end
      m_fin = fin_next;
    end
    @(negedge clk);
    if (bus.res_valid === 1'b1) n_vld++;
    chk("res_valid", 32'(bus.res_valid), 32'(exp_val));
    chk("res",       bus.res,            32'(exp_res));
    chk("finish",    32'(bus.finish),    32'(m_fin));
  endtask

  task automatic wr(input logic [7:0] b);  step(3'd2, 1'b1, b, 1'b0, 4'd0, 1'b0); endtask
  task automatic ld(input logic [3:0] w);  step(3'd1, 1'b0, 8'd0, 1'b1, w, 1'b0); endtask
  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step(3'd2, 1'b0, 8'd0, 1'b0, 4'd0, 1'b0);
  endtask
  task automatic do_end();  step(3'd0, 1'b0, 8'd0, 1'b0, 4'd0, 1'b0); endtask
  task automatic do_rst();  step(3'd2, 1'b0, 8'd0, 1'b0, 4'd0, 1'b1); endtask

  initial begin
    model_reset();
    bus.ctrl = 3'd2; bus.i_valid = 0; bus.i_data = 0; bus.w_valid = 0; bus.w_data = 0;
    rst = 1'b1;
    do_rst();
    do_rst();

    // Bytes 10,20,30 with weight 3, then weight 15 on the same buffer
    wr(8'd10); wr(8'd20); wr(8'd30);
    ld(4'd3);  hold(4);
    ld(4'd15); hold(4);
    // Saturation / wrap boundary
    wr(8'd255); wr(8'd1); wr(8'd0);
    ld(4'd15); hold(4);
    // ctrl=1 without w_valid does nothing
    step(3'd1, 1'b0, 8'd0, 1'b0, 4'd7, 1'b0); hold(2);

    // Full job: 12 results then END
    do_rst();
    n_vld = 0;
    wr(8'd11); wr(8'd22); wr(8'd33);
    ld(4'd5); hold(2); ld(4'd9); hold(2);
    wr(8'd44); wr(8'd55); wr(8'd66);
    ld(4'd5); hold(2); ld(4'd9); hold(3);
    do_end(); hold(3);
    chk("job_results", 32'(n_vld), 32'd12);
    // LOAD_W after finish is ignored
    ld(4'd7); hold(4);

    // Reset at the edge producing the second result
    do_rst();
    wr(8'd100); wr(8'd101); wr(8'd102);
    ld(4'd2); hold(1);
    n_vld = 0;
    do_rst(); hold(4);
    chk("rst_no_more", 32'(n_vld), 32'd0);

    // END during a burst: all results still delivered
    wr(8'd7); wr(8'd8); wr(8'd9);
    n_vld = 0;
    ld(4'd4); do_end(); hold(5);
    chk("end_in_burst", 32'(n_vld), 32'd3);

    // END before any burst is ignored
    do_rst(); do_end(); hold(3);

    // Randomized jobs including restarts and writes during bursts
    for (int j = 0; j < 8; j++) begin
      do_rst();
      for (int i = 0; i < 3; i++) wr(8'($urandom_range(0, 255)));
      for (int l = 0; l < 4; l++) begin
        ld(4'($urandom_range(0, 15)));
        for (int h = 0; h < int'($urandom_range(0, 3)); h++)
          step(3'($urandom_range(2, 7)), 1'($urandom_range(0, 1)),
               8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), 1'b0);
      end
      hold(3);
      if ($urandom_range(0, 1) == 1) do_end();
      hold(3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
